seq_multiplier: RTL

//   Multi-cycle shift-and-add multiplier for the MIPS MULT/MULTU path; the

---
 rtl/seq_multiplier.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/seq_multiplier.sv
// -----------------------------------------------------------------------------
// seq_multiplier
//   Multi-cycle shift-and-add multiplier for the MULT/MULTU path. After a start
//   is accepted, one multiplier bit is consumed per cycle over WIDTH RUN cycles.
//   The 2*WIDTH-bit product is then presented on hi/lo, and done pulses for one
//   FINISH cycle.
//
//   Optional feature macro: SIGNED_MULT_EN
//     defined   : is_signed=1 multiplies two's-complement operands. The operand
//                 magnitudes are multiplied, and the result is negated when the
//                 operand signs differ.
//     undefined : is_signed is ignored, and every operation is unsigned.
//
// Parameters
//   WIDTH      operand width (min 4); the product is 2*WIDTH bits
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   start      launch request, sampled only in IDLE
//   is_signed  1 = MULT (signed), 0 = MULTU
//   a, b       multiplicand / multiplier, captured on an accepted start
//   busy       high in RUN and FINISH
//   done       one-cycle pulse in FINISH; hi/lo hold the new product
//   hi, lo     upper / lower half of the last completed product
// -----------------------------------------------------------------------------
module seq_multiplier #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        FINISH = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       count_q, count_d;
    logic [WIDTH-1:0]    mcand_q, mcand_d;   // multiplicand, held for the whole run
    logic [WIDTH-1:0]    mplier_q, mplier_d; // multiplier; product low bits shift in from the top
    logic [WIDTH-1:0]    acc_q, acc_d;       // upper half of the partial product
    logic [WIDTH-1:0]    hi_q, hi_d;
    logic [WIDTH-1:0]    lo_q, lo_d;

    // One shift-and-add step. The extra top bit keeps the carry of the add,
    // and that carry moves back into acc when the pair shifts right.
    logic [WIDTH:0]      sum;
    logic [WIDTH-1:0]    acc_next;
    logic [WIDTH-1:0]    mplier_next;
    logic [2*WIDTH-1:0]  prod_final;
    logic [2*WIDTH-1:0]  result;
    logic [WIDTH-1:0]    op_a;
    logic [WIDTH-1:0]    op_b;

    assign sum         = {1'b0, acc_q} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    assign acc_next    = sum[WIDTH:1];
    assign mplier_next = {sum[0], mplier_q[WIDTH-1:1]};
    assign prod_final  = {acc_next, mplier_next};

`ifdef SIGNED_MULT_EN
    logic neg_q, neg_d;
    logic neg_accept;

    // Use the magnitudes. The most-negative value negates to itself, and read
    // as unsigned that is exactly 2^(WIDTH-1), so it needs no special case.
    assign op_a       = (is_signed && a[WIDTH-1]) ? -a : a;
    assign op_b       = (is_signed && b[WIDTH-1]) ? -b : b;
    assign neg_accept = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
    assign result     = neg_q ? -prod_final : prod_final;
`else
    logic unused_is_signed;

    assign unused_is_signed = is_signed;
    assign op_a             = a;
    assign op_b             = b;
    assign result           = prod_final;
`endif

    // NOTE: every next-state signal gets a hold default before the case
    // statement. A path that forgets an assignment then keeps the register
    // value instead of inferring a latch.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
`ifdef SIGNED_MULT_EN
        neg_d    = neg_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d  = RUN;
                    count_d  = '0;
                    mcand_d  = op_a;
                    mplier_d = op_b;
                    acc_d    = '0;
`ifdef SIGNED_MULT_EN
                    neg_d    = neg_accept;
`endif
                end
            end
            RUN: begin
                acc_d    = acc_next;
                mplier_d = mplier_next;
                count_d  = count_q + CW'(1);
                if (count_q == LAST_COUNT) begin
                    // Write hi/lo on the same edge that raises done.
                    state_d       = FINISH;
                    count_d       = '0;
                    {hi_d, lo_d}  = result;
                end
            end
            FINISH: begin
                // start is not sampled here. The earliest re-accept is the
                // following IDLE cycle.
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples the pre-edge value of every other register.
    // NOTE: the datapath registers are reset along with the FSM, so hi/lo read
    // as zero after reset and no stale operands survive an abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            count_q  <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
`ifdef SIGNED_MULT_EN
            neg_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
`ifdef SIGNED_MULT_EN
            neg_q    <= neg_d;
`endif
        end
    end

    assign busy = (state_q != IDLE);
    assign done = (state_q == FINISH);
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule
